// File: rtl/exa_crosb_output_packet_mux_with_vcs.sv
// Crossbar output-port packet mux: locks onto the arbiter-granted input and forwards whole packets through a 2-entry FIFO.
// Optional per-VC packet counters are built when EXA_CROSB_OUTMUX_STATS_EN is defined.
module exa_crosb_output_packet_mux_with_vcs #(
    parameter int input_num  = 4,
    parameter int vc_num     = 3,
    parameter int prio_num   = 2,
    parameter int data_width = 64,
    localparam int VCN  = vc_num * prio_num,
    localparam int VCW  = (VCN > 1) ? $clog2(VCN) : 1,
    localparam int SELW = (input_num > 1) ? $clog2(input_num) : 1
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic                                  i_cts,
    input  logic [SELW-1:0]                       i_input_sel,
    output logic                                  o_arb_last,
    input  logic [input_num-1:0]                  i_valid,
    input  logic [input_num-1:0][data_width-1:0]  i_data,
    input  logic [input_num-1:0][VCW-1:0]         i_vc,
    input  logic [input_num-1:0]                  i_last,
    output logic [input_num-1:0]                  o_ready,
    output logic                                  o_valid,
    output logic [data_width-1:0]                 o_data,
    output logic [VCW-1:0]                        o_vc,
    output logic                                  o_last,
    input  logic                                  i_ready
`ifdef EXA_CROSB_OUTMUX_STATS_EN
    ,
    output logic [VCN-1:0][31:0]                  o_pkt_cnt
`endif
);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    typedef struct packed {
        logic                  last;
        logic [VCW-1:0]        vc;
        logic [data_width-1:0] data;
    } beat_t;

    state_t          r_state, w_state_nxt;
    logic [SELW-1:0] r_sel, w_sel_nxt;
    logic            r_arb_last, w_arb_last_nxt;
    beat_t           r_mem [2];
    logic            r_wr_ptr, r_rd_ptr;
    logic [1:0]      r_count;

    logic            w_full, w_push, w_pop, w_sel_ok;
    beat_t           w_in, w_head;

    assign w_full   = (r_count == 2'd2);
    assign w_sel_ok = ({1'b0, i_input_sel} < (SELW+1)'(input_num));
    assign w_in     = '{last: i_last[r_sel], vc: i_vc[r_sel], data: i_data[r_sel]};
    assign w_head   = r_mem[r_rd_ptr];

    // Only the locked input may see ready, and a full FIFO never passes through even when popping.
    always_comb begin
        o_ready = '0;
        if (r_state == ST_LOCKED && !w_full)
            o_ready[r_sel] = 1'b1;
    end

    assign w_push = |(o_ready & i_valid);
    assign w_pop  = o_valid & i_ready;

    assign o_valid    = (r_count != 2'd0);
    assign o_data     = o_valid ? w_head.data : '0;
    assign o_vc       = o_valid ? w_head.vc   : '0;
    assign o_last     = o_valid ? w_head.last : 1'b0;
    assign o_arb_last = r_arb_last;

    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_arb_last_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_cts && w_sel_ok) begin
                    w_state_nxt = ST_LOCKED;
                    w_sel_nxt   = i_input_sel;
                end
            end
            ST_LOCKED: begin
                if (w_push && w_in.last) begin
                    w_state_nxt    = ST_IDLE;
                    w_arb_last_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_sel      <= '0;
            r_arb_last <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_arb_last <= w_arb_last_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_in;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef EXA_CROSB_OUTMUX_STATS_EN
    logic [VCN-1:0][31:0] r_pkt_cnt;

    // One count per packet leaving the port, keyed by the tag on its last beat.
    for (genvar v = 0; v < VCN; v++) begin : g_stats
        always_ff @(posedge clk) begin
            if (!resetn)
                r_pkt_cnt[v] <= '0;
            else if (w_pop && o_last && (o_vc == VCW'(v)) && (r_pkt_cnt[v] != 32'hFFFF_FFFF))
                r_pkt_cnt[v] <= r_pkt_cnt[v] + 32'd1;
        end
    end

    assign o_pkt_cnt = r_pkt_cnt;
`endif

endmodule
